// File: rtl/pwm_servo_pkg.sv
// Shared servo PWM timing package: FSM states, default 50 MHz timing and the
// cycles-per-position-step helper used by both the generator and the decoder.
package pwm_servo_pkg;

    typedef enum logic [1:0] {
        ARM,
        WAIT_RISE,
        HIGH
    } pwm_state_t;

    localparam int unsigned CLK_HZ               = 50_000_000;
    localparam int unsigned FRAME_CYCLES         = 1_000_000;
    localparam int unsigned DEF_PULSE_MIN_CYCLES = 50_000;
    localparam int unsigned DEF_PULSE_MAX_CYCLES = 100_000;
    localparam int unsigned DEF_TIMEOUT_CYCLES   = 1_250_000;
    localparam int unsigned DEF_POS_WIDTH        = 7;

    function automatic int unsigned step_cycles(input int unsigned pulse_min,
                                                input int unsigned pulse_max,
                                                input int unsigned pos_width);
        return (pulse_max - pulse_min) / ((32'd1 << pos_width) - 32'd1);
    endfunction

endpackage

// File: rtl/pwm_servo_decoder_if.sv
// Servo decoder channel bundle: the raw PWM line in and the decoded position/flags out.
interface pwm_servo_decoder_if
    import pwm_servo_pkg::*;
#(
    parameter int unsigned POS_WIDTH = DEF_POS_WIDTH
);
    logic                 pwm_in;
    logic [POS_WIDTH-1:0] position;
    logic                 pos_valid;
    logic                 new_sample;
    logic                 out_of_range;
    logic                 timeout;

    modport master (
        input  pwm_in,
        output position, pos_valid, new_sample, out_of_range, timeout
    );

    modport slave (
        output pwm_in,
        input  position, pos_valid, new_sample, out_of_range, timeout
    );
endinterface

// File: rtl/pwm_servo_decoder_sync_edge_detect.sv
// Synchronizer chain for the asynchronous PWM line plus registered level and
// rise/fall strobes (strobes coincide with the level change).
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            level  <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~level;
            fall   <= ~sync_q[SYNC_STAGES-1] & level;
        end
    end
endmodule

// File: rtl/pwm_servo_decoder.sv
// Servo PWM decoder: measures the high time of each frame and recovers the position code.
// Optional PWM_DECODER_AVG_EN: report the rounded mean of the last 4 clean samples.
module pwm_servo_decoder
    import pwm_servo_pkg::*;
#(
    parameter int unsigned PULSE_MIN_CYCLES = DEF_PULSE_MIN_CYCLES,
    parameter int unsigned PULSE_MAX_CYCLES = DEF_PULSE_MAX_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
    parameter int unsigned POS_WIDTH        = DEF_POS_WIDTH,
    parameter int unsigned SYNC_STAGES      = 2
) (
    input logic clk,
    input logic rst,
    pwm_servo_decoder_if.master bus
);
    localparam int unsigned CW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned STEP_CYCLES = step_cycles(PULSE_MIN_CYCLES, PULSE_MAX_CYCLES, POS_WIDTH);
    localparam int unsigned SW          = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned SETTLE      = SYNC_STAGES + 2;
    localparam int unsigned ZW          = $clog2(SETTLE + 1);

    localparam logic [CW-1:0] MIN_C     = CW'(PULSE_MIN_CYCLES);
    localparam logic [CW-1:0] MAX_C     = CW'(PULSE_MAX_CYCLES);
    localparam logic [CW-1:0] TO_C      = CW'(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [ZW-1:0] SETTLE_C  = ZW'(SETTLE);

    logic level, rise, fall;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    pwm_state_t           state;
    logic [ZW-1:0]        settle_cnt;
    logic [CW-1:0]        frame_cnt;
    logic [CW-1:0]        high_cnt;
    logic [SW-1:0]        step_cnt;
    logic [POS_WIDTH-1:0] acc;
    logic [POS_WIDTH-1:0] position_q;
    logic                 pos_valid_q, new_sample_q, oor_q, timeout_q;
    logic                 timeout_hit, oor_now;

    always_comb begin
        timeout_hit = ((state == WAIT_RISE) && (frame_cnt == TO_C)) ||
                      ((state == HIGH) && (high_cnt == TO_C));
        oor_now     = (high_cnt < MIN_C) || (high_cnt > MAX_C);
    end

`ifdef PWM_DECODER_AVG_EN
    localparam int unsigned SUMW = POS_WIDTH + 2;
    // Three previous clean samples; the pulse being closed out is the fourth.
    logic [POS_WIDTH-1:0] hist_q [3];
    logic [1:0]           fill_q;
    logic [SUMW-1:0]      avg_sum;

    always_comb begin
        avg_sum = SUMW'(acc) + SUMW'(hist_q[0]) + SUMW'(hist_q[1]) +
                  SUMW'(hist_q[2]) + SUMW'(2);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARM;
            settle_cnt   <= '0;
            frame_cnt    <= '0;
            high_cnt     <= '0;
            step_cnt     <= '0;
            acc          <= '0;
            position_q   <= '0;
            pos_valid_q  <= 1'b0;
            new_sample_q <= 1'b0;
            oor_q        <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef PWM_DECODER_AVG_EN
            hist_q       <= '{default: '0};
            fill_q       <= '0;
`endif
        end else begin
            new_sample_q <= 1'b0;
            if (state == ARM)
                frame_cnt <= '0;
            else if (frame_cnt != TO_C)
                frame_cnt <= frame_cnt + CW'(1);

            if (timeout_hit) begin
                state       <= ARM;
                settle_cnt  <= '0;
                timeout_q   <= 1'b1;
                pos_valid_q <= 1'b0;
`ifdef PWM_DECODER_AVG_EN
                fill_q      <= '0;
`endif
            end else begin
                unique case (state)
                    // Require the line to sit low for the whole sync/edge pipeline
                    // depth, so a pulse already high at reset is never measured.
                    ARM: begin
                        if (level)
                            settle_cnt <= '0;
                        else if (settle_cnt == SETTLE_C)
                            state <= WAIT_RISE;
                        else
                            settle_cnt <= settle_cnt + ZW'(1);
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            state     <= HIGH;
                            frame_cnt <= CW'(1);
                            high_cnt  <= CW'(1);
                            step_cnt  <= '0;
                            acc       <= '0;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state        <= WAIT_RISE;
                            new_sample_q <= 1'b1;
                            timeout_q    <= 1'b0;
                            oor_q        <= oor_now;
`ifdef PWM_DECODER_AVG_EN
                            if (!oor_now) begin
                                hist_q[0] <= acc;
                                hist_q[1] <= hist_q[0];
                                hist_q[2] <= hist_q[1];
                                if (fill_q == 2'd3) begin
                                    position_q  <= avg_sum[SUMW-1:2];
                                    pos_valid_q <= 1'b1;
                                end else begin
                                    fill_q <= fill_q + 2'd1;
                                end
                            end
`else
                            position_q  <= acc;
                            pos_valid_q <= 1'b1;
`endif
                        end else begin
                            if (high_cnt != TO_C)
                                high_cnt <= high_cnt + CW'(1);
                            if (high_cnt >= MIN_C) begin
                                if (step_cnt == STEP_LAST) begin
                                    step_cnt <= '0;
                                    if (acc != '1)
                                        acc <= acc + POS_WIDTH'(1);
                                end else begin
                                    step_cnt <= step_cnt + SW'(1);
                                end
                            end
                        end
                    end
                    default: state <= ARM;
                endcase
            end
        end
    end

    assign bus.position     = position_q;
    assign bus.pos_valid    = pos_valid_q;
    assign bus.new_sample   = new_sample_q;
    assign bus.out_of_range = oor_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: doc/pwm_servo_decoder.md
Name: pwm_servo_decoder

Overview:
Reads one servo PWM line (20 ms frame, 1–2 ms high pulse) and recovers the 7-bit position code that produced it. This is the inverse of the pwm_servos generator.
- Used in closed-loop self-check of the arm outputs.
- Also captures commands from an external RC/servo source into the x/y/z position path.
- One instance per servo channel; outputs feed the display/mux path like x_mem/x_accel.

Parameters:
PULSE_MIN_CYCLES, 50_000, high-time clocks mapping to position 0 (1 ms @ 50 MHz)
PULSE_MAX_CYCLES, 100_000, high-time clocks mapping to full scale (2 ms)
TIMEOUT_CYCLES, 1_250_000, max clocks between rising edges or of one high phase (25 ms)
POS_WIDTH, 7, width of recovered position code
SYNC_STAGES, 2, input synchronizer flops (min 2)

Ports:
clk  input  1  system clock (MAX10_CLK1_50 at top)
rst  input  1  synchronous, active-high reset
pwm_in  input  1  asynchronous servo PWM line
position  output  POS_WIDTH  last decoded position code
pos_valid  output  1  level: position reflects a good pulse since last reset/timeout
new_sample  output  1  one-cycle strobe when position/flags update
out_of_range  output  1  last pulse was below PULSE_MIN_CYCLES or above PULSE_MAX_CYCLES
timeout  output  1  level: no valid frame within TIMEOUT_CYCLES

Behaviour:
- Reset (sync, active-high): all outputs 0, synchronizer flops 0, counters 0, FSM in ARM.
- Input path:
  - pwm_in passes through SYNC_STAGES flops, then a 1-flop edge detector.
  - Edges are acted on in the cycle after the synchronizer output changes.
- Derived constant: STEP_CYCLES = (PULSE_MAX_CYCLES-PULSE_MIN_CYCLES)/(2**POS_WIDTH-1), integer division. Default gives 393.
- FSM states:
  - ARM: wait until synchronized input is 0. This discards a partial pulse after reset or timeout. Go to WAIT_RISE.
  - WAIT_RISE: frame counter runs. On a rising edge: clear high counter, step counter and pos accumulator; go to HIGH.
  - HIGH: high counter increments every cycle.
    - Once the high count ≥ PULSE_MIN_CYCLES, the step counter runs. Each STEP_CYCLES clocks it increments pos accumulator, which saturates at 2**POS_WIDTH-1.
    - On a falling edge: go to WAIT_RISE and enter the UPDATE action in the same transition.
- UPDATE, on the falling-edge cycle; all registered outputs change together on the next clock edge:
  - position ← accumulator; new_sample=1 for exactly one cycle; pos_valid=1; timeout=0.
  - out_of_range=1 if high_count < PULSE_MIN_CYCLES (position=0) or high_count > PULSE_MAX_CYCLES (position saturated).
- Latency: raw pwm_in falling edge to new_sample = SYNC_STAGES+2 clocks (4 at default).
- Frame counter: reset on every rising edge, saturating.
- Timeout:
  - Triggers if the frame counter reaches TIMEOUT_CYCLES in WAIT_RISE, or the high counter reaches TIMEOUT_CYCLES in HIGH (stuck-high line).
  - Effect: timeout=1, pos_valid=0, position holds its last value, no new_sample, FSM → ARM.
- Simultaneous timeout and edge in the same cycle: timeout wins.
- Reset mid-pulse: everything cleared; that pulse is ignored, because ARM requires a low first.
- Counter widths: $clog2(TIMEOUT_CYCLES+1); no wrap is possible because the counters saturate.

Optional Feature:
PWM_DECODER_AVG_EN
- When defined: position is the rounded mean of the last 4 decoded samples, computed as (sum+2)>>2 over a 4-entry shift buffer. Only clean, in-range pulses enter the buffer.
  - pos_valid asserts only after 4 samples have been collected since reset/timeout; timeout flushes the buffer.
  - new_sample still fires on every pulse, including out-of-range ones.
- When undefined: position is the single latest sample; no buffer logic is synthesized.

Decomposition:
- Shared package pwm_servo_pkg holds:
  - the FSM state enum (ARM, WAIT_RISE, HIGH);
  - default timing constants (CLK_HZ=50_000_000, FRAME_CYCLES=1_000_000, PULSE_MIN/MAX);
  - a STEP_CYCLES function.
- pwm_servos reuses the same package so generator and decoder share one scale.
- One natural sub-module: sync_edge_detect, covering the synchronizer and rise/fall strobes.

Test Plan:
(Scaled sim parameters are allowed; values below are at defaults.)
- 1.5 ms pulse (75_000 clk high) in a 20 ms frame → position=63 (25_000/393), pos_valid=1, new_sample single pulse 4 clocks after the raw fall, out_of_range=0.
- 1.0 ms pulse → position=0, out_of_range=0. 2.0 ms pulse → position=127, out_of_range=0.
- 0.5 ms pulse → position=0, out_of_range=1. 2.5 ms pulse → position=127, out_of_range=1.
- Line held low 30 ms after a valid frame → timeout=1 and pos_valid=0 exactly 1_250_000 clocks after the last rise; position holds. The next full frame clears timeout.
- rst asserted mid-pulse (pwm_in high) → outputs 0. The remainder of that pulse produces no new_sample; the next full 1.5 ms pulse gives 63.
- PWM_DECODER_AVG_EN: pulses decoding to 10, 20, 30, 40 → pos_valid rises on the 4th pulse with position=25. pwm_in held high 30 ms → timeout=1 and buffer flushed.
